// File: rtl/fp_pkg.sv
// Shared floating-point constants and types for the FP datapath blocks.
package fp_pkg;

  // RISC-V rounding-mode encodings
  localparam logic [2:0] RmRne = 3'b000;
  localparam logic [2:0] RmRtz = 3'b001;
  localparam logic [2:0] RmRdn = 3'b010;
  localparam logic [2:0] RmRup = 3'b011;
  localparam logic [2:0] RmRmm = 3'b100;

  // fflags bit positions, {NV,DZ,OF,UF,NX}
  localparam int unsigned FlagNv = 4;
  localparam int unsigned FlagDz = 3;
  localparam int unsigned FlagOf = 2;
  localparam int unsigned FlagUf = 1;
  localparam int unsigned FlagNx = 0;

  // Single-precision exponent bias; the all-ones exponent field marks overflow
  localparam int Bias   = 127;
  localparam int ExpInf = 2 * Bias + 1;

  localparam logic [31:0] MaxFinite = 32'h7F7F_FFFF;
  localparam logic [31:0] Inf       = 32'h7F80_0000;

  localparam int unsigned DefShiftStep = 4;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StRound,
    StOut
  } dd_state_e;

endpackage

// File: rtl/fp_round_incr.sv
// Rounding increment decision shared by the FP units.
module fp_round_incr
  import fp_pkg::*;
(
  input  logic [2:0] rm,
  input  logic       sign,
  input  logic       lsb,
  input  logic       guard,
  input  logic       sticky,
  output logic       increment
);

  // Decide whether the truncated magnitude must be bumped by one ulp
  always_comb begin
    increment = 1'b0;
    case (rm)
      RmRtz:   increment = 1'b0;
      RmRdn:   increment = sign & (guard | sticky);
      RmRup:   increment = ~sign & (guard | sticky);
      RmRmm:   increment = guard;
      // RNE, and the reserved codes behave as RNE
      default: increment = guard & (sticky | lsb);
    endcase
  end

endmodule

// File: rtl/div_denorm.sv
// Divider back end: denormalises tiny quotients, rounds, and packs an IEEE single.
module div_denorm
  import fp_pkg::*;
#(
  parameter int unsigned SHIFT_STEP = DefShiftStep
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_Sign,
  input  logic [9:0]  in_Exp,
  input  logic [25:0] in_Mant,
  input  logic        in_Sticky,
  input  logic [2:0]  in_Rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_Result,
  output logic [4:0]  out_Flags
);

  localparam int unsigned MaxShift  = 26;
  localparam int unsigned StepClamp = (SHIFT_STEP == 0) ? 1 :
                                      (SHIFT_STEP > MaxShift) ? MaxShift : SHIFT_STEP;
  localparam logic [4:0] Step = 5'(StepClamp);
  localparam logic signed [10:0] ExpOvf = 11'(ExpInf);

  dd_state_e   state_q, state_d;
  logic        sign_q, sign_d;
  logic [9:0]  exp_q, exp_d;
  logic [25:0] mant_q, mant_d;
  logic        sticky_q, sticky_d;
  logic [2:0]  rm_q, rm_d;
  logic        subn_q, subn_d;
  logic        zero_q, zero_d;
  logic [4:0]  rem_q, rem_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  flags_q, flags_d;

  // Accept-time decode: the operand is tiny when its biased exponent is not positive
  logic              exp_le0;
  logic signed [10:0] n_full;
  logic [4:0]        n_sat;
  assign exp_le0 = $signed(in_Exp) <= 10'sd0;
  assign n_full  = 11'sd1 - $signed({in_Exp[9], in_Exp});
  assign n_sat   = (n_full > 11'sd26) ? 5'd26 : n_full[4:0];

  // Per-cycle shift amount and the bits it pushes out into sticky
  logic [4:0]  shamt;
  logic [25:0] lost_mask;
  assign shamt     = (rem_q > Step) ? Step : rem_q;
  assign lost_mask = (26'd1 << shamt) - 26'd1;

  logic        incr;
  logic [24:0] mant_rnd;
  logic [10:0] exp_rnd;
  logic        inexact, ovf, max_fin;
  logic [7:0]  exp_fld;
  logic [22:0] frac;
  logic [31:0] rnd_result;
  logic [4:0]  rnd_flags;

  fp_round_incr u_round_incr (
    .rm        (rm_q),
    .sign      (sign_q),
    .lsb       (mant_q[2]),
    .guard     (mant_q[1]),
    .sticky    (mant_q[0] | sticky_q),
    .increment (incr)
  );

  // Round, detect overflow/underflow and pack the result word
  always_comb begin
    mant_rnd = {1'b0, mant_q[25:2]} + {24'd0, incr};
    exp_rnd  = {exp_q[9], exp_q} + {10'd0, mant_rnd[24]};
    inexact  = mant_q[1] | mant_q[0] | sticky_q;
    ovf      = ~zero_q & ($signed(exp_rnd) >= ExpOvf);
    max_fin  = (rm_q == RmRtz) | ((rm_q == RmRdn) & ~sign_q) | ((rm_q == RmRup) & sign_q);
    if (subn_q) begin
      // A subnormal that rounds into bit 23 becomes the smallest normal
      exp_fld = {7'd0, mant_rnd[23]};
      frac    = mant_rnd[22:0];
    end else if (mant_rnd[24]) begin
      exp_fld = exp_q[7:0] + 8'd1;
      frac    = '0;
    end else begin
      exp_fld = exp_q[7:0];
      frac    = mant_rnd[22:0];
    end
    rnd_result = {sign_q, exp_fld, frac};
    rnd_flags  = '0;
    if (zero_q) begin
      rnd_result = {sign_q, 31'd0};
    end else if (ovf) begin
      rnd_result         = {sign_q, max_fin ? MaxFinite[30:0] : Inf[30:0]};
      rnd_flags[FlagOf]  = 1'b1;
      rnd_flags[FlagNx]  = 1'b1;
    end else begin
      rnd_flags[FlagNx]  = inexact;
      rnd_flags[FlagUf]  = inexact & (exp_fld == 8'd0);
    end
    rnd_flags[FlagNv] = 1'b0;
    rnd_flags[FlagDz] = 1'b0;
  end

  // Next-state logic for the IDLE/SHIFT/ROUND/OUT sequence
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    sticky_d = sticky_q;
    rm_d     = rm_q;
    subn_d   = subn_q;
    zero_d   = zero_q;
    rem_d    = rem_q;
    result_d = result_q;
    flags_d  = flags_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d   = in_Sign;
          exp_d    = in_Exp;
          mant_d   = in_Mant;
          sticky_d = in_Sticky;
          rm_d     = in_Rm;
          zero_d   = (in_Mant == 26'd0);
          subn_d   = exp_le0 & (in_Mant != 26'd0);
          rem_d    = n_sat;
          state_d  = (exp_le0 && in_Mant != 26'd0) ? StShift : StRound;
        end
      end
      StShift: begin
        mant_d   = mant_q >> shamt;
        sticky_d = sticky_q | (|(mant_q & lost_mask));
        rem_d    = rem_q - shamt;
        if (rem_q == shamt) begin
          exp_d   = '0;
          state_d = StRound;
        end
      end
      StRound: begin
        result_d = rnd_result;
        flags_d  = rnd_flags;
        state_d  = StOut;
      end
      StOut: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      sticky_q <= 1'b0;
      rm_q     <= '0;
      subn_q   <= 1'b0;
      zero_q   <= 1'b0;
      rem_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      sticky_q <= sticky_d;
      rm_q     <= rm_d;
      subn_q   <= subn_d;
      zero_q   <= zero_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready   = (state_q == StIdle) & rst_n;
  assign out_valid  = (state_q == StOut);
  assign out_Result = result_q;
  assign out_Flags  = flags_q;

endmodule

// File: tb/tb_div_denorm.sv
// Self-checking bench for div_denorm: directed corner cases plus random operands.
module tb_div_denorm;
  import fp_pkg::*;

  localparam int Step = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_Sign = 1'b0;
  logic [9:0]  in_Exp = '0;
  logic [25:0] in_Mant = '0;
  logic        in_Sticky = 1'b0;
  logic [2:0]  in_Rm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_Result;
  logic [4:0]  out_Flags;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  div_denorm #(.SHIFT_STEP(Step)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_Sign    (in_Sign),
    .in_Exp     (in_Exp),
    .in_Mant    (in_Mant),
    .in_Sticky  (in_Sticky),
    .in_Rm      (in_Rm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_Result (out_Result),
    .out_Flags  (out_Flags)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: one-shot denormalise, round by mode, pack with integer arithmetic
  function automatic void model(input bit s, input int e, input logic [25:0] m, input bit st,
                                input logic [2:0] rm, output logic [31:0] res,
                                output logic [4:0] fl, output int lat);
    longint mm, q, p;
    int n, ex;
    bit g, r, nx, inc, subn, uf, maxfin, sb;
    lat = 2;
    res = {s, 31'd0};
    fl  = '0;
    if (m == 26'd0) return;
    subn = (e <= 0);
    mm   = longint'(m);
    ex   = e;
    sb   = st;
    if (subn) begin
      n = 1 - e;
      if (n > 26) n = 26;
      lat = 2 + (n + Step - 1) / Step;
      p = longint'(1) << n;
      if ((mm % p) != 0) sb = 1'b1;
      mm = mm / p;
      ex = 0;
    end
    g  = mm[1];
    r  = mm[0] | sb;
    q  = mm / 4;
    nx = g | r;
    case (rm)
      3'd1:    inc = 1'b0;
      3'd2:    inc = s & nx;
      3'd3:    inc = !s & nx;
      3'd4:    inc = g;
      default: inc = g & (r | q[0]);
    endcase
    q = q + longint'(inc);
    if (!subn && q == (longint'(1) << 24)) begin
      ex = ex + 1;
      q  = q / 2;
    end
    if (ex >= 255) begin
      maxfin = (rm == 3'd1) || (rm == 3'd2 && !s) || (rm == 3'd3 && s);
      res = maxfin ? {s, 31'h7F7F_FFFF} : {s, 31'h7F80_0000};
      fl  = 5'b00101;
    end else if (subn) begin
      uf  = nx && (q < (longint'(1) << 23));
      res = {s, q[30:0]};
      fl  = {3'b000, uf, nx};
    end else begin
      res = {s, ex[7:0], q[22:0]};
      fl  = {4'b0000, nx};
    end
  endfunction

  // One full transaction: accept, wait with junk on the inputs, check, optional backpressure
  task automatic run_op(input string tag, input bit s, input int e, input logic [25:0] m,
                        input bit st, input logic [2:0] rm, input int hold,
                        input logic [31:0] er, input logic [4:0] ef, input int lat);
    int cnt;
    chk({tag, "/in_ready_idle"}, {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_Sign   = s;
    in_Exp    = 10'(e);
    in_Mant   = m;
    in_Sticky = st;
    in_Rm     = rm;
    tick();
    cnt = 1;
    in_Sign   = 1'($urandom);
    in_Exp    = 10'($urandom);
    in_Mant   = 26'($urandom);
    in_Sticky = 1'($urandom);
    in_Rm     = 3'($urandom);
    chk({tag, "/in_ready_busy"}, {31'd0, in_ready}, 32'd0);
    while (!out_valid && cnt < 64) begin
      tick();
      cnt++;
    end
    chk({tag, "/out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "/latency"}, cnt, lat);
    chk({tag, "/result"}, out_Result, er);
    chk({tag, "/flags"}, {27'd0, out_Flags}, {27'd0, ef});
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "/hold_result"}, out_Result, er);
      chk({tag, "/hold_flags"}, {27'd0, out_Flags}, {27'd0, ef});
      chk({tag, "/hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "/hold_valid"}, {31'd0, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "/valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "/in_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] er;
    logic [4:0]  ef;
    int          lat, e, sel;
    logic [25:0] m;
    bit          seen;

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst/in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst/out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst/result", out_Result, 32'd0);
    chk("rst/flags", {27'd0, out_Flags}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst/in_ready_release", {31'd0, in_ready}, 32'd1);

    // Directed corner cases with independently derived expectations
    run_op("one",      0, 127,  {24'h800000, 2'b00}, 0, RmRne, 0, 32'h3F80_0000, 5'h00, 2);
    run_op("rne_tie",  0, 127,  {24'h800001, 2'b10}, 0, RmRne, 0, 32'h3F80_0002, 5'h01, 2);
    run_op("rtz_tie",  0, 127,  {24'h800001, 2'b10}, 0, RmRtz, 0, 32'h3F80_0001, 5'h01, 2);
    run_op("rmm",      0, 127,  {24'h800000, 2'b10}, 0, RmRmm, 0, 32'h3F80_0001, 5'h01, 2);
    run_op("rsvd_rm",  0, 127,  {24'h800001, 2'b10}, 0, 3'b101, 0, 32'h3F80_0002, 5'h01, 2);
    run_op("sub_e-2",  0, -2,   {24'h800000, 2'b00}, 0, RmRne, 0, 32'h0010_0000, 5'h00, 3);
    run_op("sat_rup",  0, -100, {24'h800000, 2'b00}, 0, RmRup, 0, 32'h0000_0001, 5'h03, 9);
    run_op("sat_rtz",  0, -100, {24'h800000, 2'b00}, 0, RmRtz, 0, 32'h0000_0000, 5'h03, 9);
    run_op("sat_rdn",  1, -100, {24'h800000, 2'b00}, 0, RmRdn, 0, 32'h8000_0001, 5'h03, 9);
    run_op("ovf_rne",  1, 255,  {24'h800000, 2'b00}, 0, RmRne, 0, 32'hFF80_0000, 5'h05, 2);
    run_op("ovf_rtz",  1, 255,  {24'h800000, 2'b00}, 0, RmRtz, 0, 32'hFF7F_FFFF, 5'h05, 2);
    run_op("rnd_ovf",  0, 254,  {24'hFFFFFF, 2'b10}, 0, RmRne, 0, 32'h7F80_0000, 5'h05, 2);
    run_op("sub_carry", 0, 0,   {24'hFFFFFF, 2'b11}, 0, RmRne, 0, 32'h0080_0000, 5'h01, 3);
    run_op("zero",     1, -5,   26'd0,               1, RmRup, 0, 32'h8000_0000, 5'h00, 2);
    run_op("backpr",   0, 127,  {24'hC00000, 2'b11}, 1, RmRne, 5, 32'h3FC0_0001, 5'h01, 2);

    // Reset during SHIFT aborts the operation
    in_valid = 1'b1;
    in_Sign  = 1'b0;
    in_Exp   = 10'(-100);
    in_Mant  = {24'h800000, 2'b00};
    in_Sticky = 1'b0;
    in_Rm    = RmRup;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("abort/out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort/result", out_Result, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("abort/in_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    repeat (12) begin
      tick();
      seen = seen | out_valid;
    end
    chk("abort/no_result", {31'd0, seen}, 32'd0);

    // Random operands against the reference model
    for (int k = 0; k < 40; k++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 5)       e = int'($urandom_range(1, 254));
      else if (sel < 8)  e = -int'($urandom_range(0, 30));
      else if (sel == 8) e = -int'($urandom_range(31, 512));
      else               e = int'($urandom_range(250, 260));
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      m = 26'd0;
      else if (sel < 3)  m = {1'b1, 23'h7FFFFF, 2'($urandom)};
      else               m = {1'b1, 25'($urandom)};
      begin
        bit          s, st;
        logic [2:0]  rm;
        s  = 1'($urandom);
        st = 1'($urandom);
        rm = 3'($urandom_range(0, 7));
        model(s, e, m, st, rm, er, ef, lat);
        run_op($sformatf("rand%0d", k), s, e, m, st, rm, int'($urandom_range(0, 2)),
               er, ef, lat);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
